// File: rtl/sb_line_drive.sv
// Line-following motor driver: debounces the sensor bar, classifies the line position
// and runs a steering FSM that produces registered PWM/direction commands per wheel.
`timescale 1ns/1ps

module sb_line_drive #(
    parameter int N_SENS    = 3,
    parameter int PWM_W     = 8,
    parameter int DUTY_FWD  = 200,
    parameter int DUTY_TURN = 120,
    parameter int DEB_CYC   = 4,
    parameter int LOST_CYC  = 1000
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_SENS-1:0] sensor,
    output logic              l_pwm,
    output logic              r_pwm,
    output logic              l_dir,
    output logic              r_dir,
    output logic [2:0]        turn,
    output logic              motor_stopped,
    output logic              node_pulse,
    output logic              lost
);

    localparam int M       = (N_SENS - 1) / 2;
    localparam int PWM_MAX = (1 << PWM_W) - 1;
    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam int CNT_W   = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;

    localparam logic [PWM_W-1:0] FWD_DUTY  = PWM_W'((DUTY_FWD  > PWM_MAX) ? PWM_MAX : DUTY_FWD);
    localparam logic [PWM_W-1:0] TURN_DUTY = PWM_W'((DUTY_TURN > PWM_MAX) ? PWM_MAX : DUTY_TURN);

    typedef enum logic [2:0] {
        S_STOP   = 3'b000,
        S_FWD    = 3'b001,
        S_LEFT   = 3'b010,
        S_RIGHT  = 3'b011,
        S_SEARCH = 3'b100,
        S_LOST   = 3'b101,
        S_NODE   = 3'b110
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_FWD,
        C_LEFT,
        C_RIGHT,
        C_NODE
    } cls_t;

    logic [N_SENS-1:0] raw_q;
    logic [N_SENS-1:0] filt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_held;

    state_t            state;
    state_t            next_state;
    state_t            target;
    cls_t              cls;
    logic              left_any;
    logic              right_any;
    logic [CNT_W-1:0]  search_cnt;
    logic              armed;
    logic              last_right;

    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  pwm_next;
    logic [PWM_W-1:0]  l_duty;
    logic [PWM_W-1:0]  r_duty;
    logic              l_dir_n;
    logic              r_dir_n;

    // Length of the current run of identical raw samples, counting this edge.
    always_comb begin
        if (sensor != raw_q)
            deb_held = DEB_W'(1);
        else if (deb_cnt == DEB_W'(DEB_CYC))
            deb_held = deb_cnt;
        else
            deb_held = deb_cnt + DEB_W'(1);
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            raw_q   <= '0;
            deb_cnt <= '0;
            filt    <= '0;
        end else begin
            raw_q   <= sensor;
            deb_cnt <= deb_held;
            if (deb_held == DEB_W'(DEB_CYC))
                filt <= sensor;
        end
    end

    always_comb begin
        left_any  = 1'b0;
        right_any = 1'b0;
        for (int i = 0; i < N_SENS; i++) begin
            if (i > M) left_any  = left_any  | filt[i];
            if (i < M) right_any = right_any | filt[i];
        end
        if (&filt)
            cls = C_NODE;
        else if (filt == '0)
            cls = C_NONE;
        else if (left_any && !right_any)
            cls = C_LEFT;
        else if (right_any && !left_any)
            cls = C_RIGHT;
        else
            cls = C_FWD;
    end

    // A node only counts once until the bar has seen something other than all-ones.
    always_comb begin
        case (cls)
            C_NODE:  target = armed ? S_NODE : S_FWD;
            C_LEFT:  target = S_LEFT;
            C_RIGHT: target = S_RIGHT;
            C_NONE:  target = S_SEARCH;
            default: target = S_FWD;
        endcase

        next_state = state;
        case (state)
            S_STOP:                 next_state = target;
            S_FWD, S_LEFT, S_RIGHT: next_state = target;
            S_NODE:                 next_state = S_FWD;
            S_SEARCH: begin
                if (cls != C_NONE)
                    next_state = target;
                else if (search_cnt == CNT_W'(LOST_CYC - 1))
                    next_state = S_LOST;
            end
            S_LOST: begin
                if (cls != C_NONE)
                    next_state = S_FWD;
            end
            default:                next_state = S_STOP;
        endcase

        if (!enable)
            next_state = S_STOP;
    end

    // Search pivots toward the side the line was last seen on; inner wheel reverses.
    always_comb begin
        l_duty  = '0;
        r_duty  = '0;
        l_dir_n = 1'b1;
        r_dir_n = 1'b1;
        case (next_state)
            S_FWD, S_NODE: begin
                l_duty = FWD_DUTY;
                r_duty = FWD_DUTY;
            end
            S_LEFT:  r_duty = TURN_DUTY;
            S_RIGHT: l_duty = TURN_DUTY;
            S_SEARCH: begin
                l_duty  = TURN_DUTY;
                r_duty  = TURN_DUTY;
                l_dir_n = last_right;
                r_dir_n = !last_right;
            end
            default: ;
        endcase
    end

    assign pwm_next = pwm_cnt + PWM_W'(1);

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state         <= S_STOP;
            search_cnt    <= '0;
            armed         <= 1'b1;
            last_right    <= 1'b0;
            pwm_cnt       <= '0;
            turn          <= 3'b000;
            motor_stopped <= 1'b1;
            l_pwm         <= 1'b0;
            r_pwm         <= 1'b0;
            l_dir         <= 1'b1;
            r_dir         <= 1'b1;
            node_pulse    <= 1'b0;
            lost          <= 1'b0;
        end else begin
            state      <= next_state;
            search_cnt <= (state == S_SEARCH && next_state == S_SEARCH) ?
                          search_cnt + CNT_W'(1) : '0;

            if (next_state == S_NODE)
                armed <= 1'b0;
            else if (cls != C_NODE)
                armed <= 1'b1;

            if (next_state == S_LEFT)
                last_right <= 1'b0;
            else if (next_state == S_RIGHT)
                last_right <= 1'b1;

            pwm_cnt       <= pwm_next;
            turn          <= next_state;
            motor_stopped <= (next_state == S_STOP);
            l_pwm         <= (pwm_next < l_duty);
            r_pwm         <= (pwm_next < r_duty);
            l_dir         <= l_dir_n;
            r_dir         <= r_dir_n;
            node_pulse    <= (next_state == S_NODE);
            lost          <= (next_state == S_LOST);
        end
    end

endmodule

// File: tb/tb_sb_line_drive.sv
// Directed bench for sb_line_drive: walks the steering FSM through each behaviour
// with hand-derived expectations for latency, duty and strobe counts.
`timescale 1ns/1ps

module tb_sb_line_drive;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic       l_pwm, r_pwm, l_dir, r_dir;
    logic [2:0] turn;
    logic       motor_stopped, node_pulse, lost;

    int vectors     = 0;
    int miscompares = 0;

    sb_line_drive dut (
        .clk_50        (clk_50),
        .reset         (reset),
        .enable        (enable),
        .sensor        (sensor),
        .l_pwm         (l_pwm),
        .r_pwm         (r_pwm),
        .l_dir         (l_dir),
        .r_dir         (r_dir),
        .turn          (turn),
        .motor_stopped (motor_stopped),
        .node_pulse    (node_pulse),
        .lost          (lost)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic count_high(input int cycles, output int lc, output int rc);
        lc = 0;
        rc = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            lc += int'(l_pwm);
            rc += int'(r_pwm);
        end
    endtask

    task automatic wait_turn(input logic [2:0] code, input int limit, output int n);
        n = 0;
        while (turn !== code && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        enable = 1'b0;
        sensor = 3'b000;
        repeat (3) tick();
        vectors++;
        if ({turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir, node_pulse, lost} !== 10'b000_1_00_11_00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir, node_pulse, lost}, 10'b000_1_00_11_00);
        end
    endtask

    task automatic test_forward;
        int lc, rc;
        reset  = 1'b1;
        enable = 1'b1;
        sensor = 3'b010;
        tick();
        vectors++;
        if ({turn, l_dir, r_dir} !== 5'b100_01) begin
            miscompares++;
            $display("[TB] FAIL fwd_first_search: got %b expected %b", {turn, l_dir, r_dir}, 5'b100_01);
        end
        repeat (3) tick();
        vectors++;
        if (turn !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL fwd_debounce_hold: got %b expected %b", turn, 3'b100);
        end
        tick();
        vectors++;
        if ({turn, motor_stopped, l_dir, r_dir} !== 6'b001_0_11) begin
            miscompares++;
            $display("[TB] FAIL fwd_state: got %b expected %b", {turn, motor_stopped, l_dir, r_dir}, 6'b001_0_11);
        end
        count_high(256, lc, rc);
        vectors++;
        if (lc !== 200 || rc !== 200) begin
            miscompares++;
            $display("[TB] FAIL fwd_duty: got l=%0d r=%0d expected l=200 r=200", lc, rc);
        end
    endtask

    task automatic test_left_search;
        int lc, rc;
        sensor = 3'b100;
        repeat (4) tick();
        vectors++;
        if (turn !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL left_before_debounce: got %b expected %b", turn, 3'b001);
        end
        tick();
        vectors++;
        if ({turn, l_dir, r_dir} !== 5'b010_11) begin
            miscompares++;
            $display("[TB] FAIL left_state: got %b expected %b", {turn, l_dir, r_dir}, 5'b010_11);
        end
        count_high(256, lc, rc);
        vectors++;
        if (lc !== 0 || rc !== 120) begin
            miscompares++;
            $display("[TB] FAIL left_duty: got l=%0d r=%0d expected l=0 r=120", lc, rc);
        end
        sensor = 3'b000;
        repeat (5) tick();
        vectors++;
        if ({turn, l_dir, r_dir} !== 5'b100_01) begin
            miscompares++;
            $display("[TB] FAIL search_pivot_left: got %b expected %b", {turn, l_dir, r_dir}, 5'b100_01);
        end
        count_high(256, lc, rc);
        vectors++;
        if (lc !== 120 || rc !== 120) begin
            miscompares++;
            $display("[TB] FAIL search_duty: got l=%0d r=%0d expected l=120 r=120", lc, rc);
        end
    endtask

    task automatic test_lost;
        int n, lc, rc;
        sensor = 3'b010;
        wait_turn(3'b001, 20, n);
        vectors++;
        if (turn !== 3'b001 || n !== 5) begin
            miscompares++;
            $display("[TB] FAIL search_recover: got turn=%b after %0d expected turn=001 after 5", turn, n);
        end
        sensor = 3'b000;
        wait_turn(3'b100, 20, n);
        vectors++;
        if (turn !== 3'b100 || n !== 5) begin
            miscompares++;
            $display("[TB] FAIL search_entry: got turn=%b after %0d expected turn=100 after 5", turn, n);
        end
        n = 1;
        while (n < 1100) begin
            tick();
            if (turn !== 3'b100) break;
            n++;
        end
        vectors++;
        if (n !== 1000 || {turn, lost, motor_stopped} !== 5'b101_1_0) begin
            miscompares++;
            $display("[TB] FAIL lost_timeout: got %0d cycles turn=%b lost=%b expected 1000 cycles turn=101 lost=1",
                     n, turn, lost);
        end
        count_high(64, lc, rc);
        vectors++;
        if (lc !== 0 || rc !== 0 || lost !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lost_duty: got l=%0d r=%0d lost=%b expected l=0 r=0 lost=1", lc, rc, lost);
        end
        sensor = 3'b010;
        repeat (4) tick();
        vectors++;
        if (turn !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL lost_hold: got %b expected %b", turn, 3'b101);
        end
        tick();
        vectors++;
        if ({turn, lost} !== 4'b001_0) begin
            miscompares++;
            $display("[TB] FAIL lost_exit: got %b expected %b", {turn, lost}, 4'b001_0);
        end
    endtask

    task automatic test_node;
        int pulses;
        sensor = 3'b111;
        repeat (4) tick();
        vectors++;
        if ({turn, node_pulse} !== 4'b001_0) begin
            miscompares++;
            $display("[TB] FAIL node_early: got %b expected %b", {turn, node_pulse}, 4'b001_0);
        end
        tick();
        vectors++;
        if ({turn, node_pulse, l_dir, r_dir} !== 6'b110_1_11) begin
            miscompares++;
            $display("[TB] FAIL node_entry: got %b expected %b", {turn, node_pulse, l_dir, r_dir}, 6'b110_1_11);
        end
        pulses = 0;
        repeat (15) begin
            tick();
            pulses += int'(node_pulse);
        end
        vectors++;
        if (pulses !== 0 || turn !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL node_single: got %0d extra pulses turn=%b expected 0 turn=001", pulses, turn);
        end
        sensor = 3'b010;
        repeat (6) tick();
        sensor = 3'b111;
        pulses = 0;
        repeat (15) begin
            tick();
            pulses += int'(node_pulse);
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL node_rearm: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_glitch;
        int bad;
        sensor = 3'b010;
        repeat (6) tick();
        sensor = 3'b110;
        repeat (2) tick();
        sensor = 3'b010;
        bad = 0;
        repeat (10) begin
            tick();
            if (turn !== 3'b001) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_reject: got %0d non-forward cycles expected 0", bad);
        end
    endtask

    task automatic test_enable_drop;
        int n, lc, rc;
        sensor = 3'b001;
        wait_turn(3'b011, 20, n);
        vectors++;
        if (turn !== 3'b011 || n !== 5) begin
            miscompares++;
            $display("[TB] FAIL right_entry: got turn=%b after %0d expected turn=011 after 5", turn, n);
        end
        count_high(256, lc, rc);
        vectors++;
        if (lc !== 120 || rc !== 0) begin
            miscompares++;
            $display("[TB] FAIL right_duty: got l=%0d r=%0d expected l=120 r=0", lc, rc);
        end
        enable = 1'b0;
        tick();
        vectors++;
        if ({turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir} !== 8'b000_1_00_11) begin
            miscompares++;
            $display("[TB] FAIL enable_stop: got %b expected %b",
                     {turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir}, 8'b000_1_00_11);
        end
        count_high(20, lc, rc);
        vectors++;
        if (lc !== 0 || rc !== 0 || turn !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL stop_hold: got l=%0d r=%0d turn=%b expected l=0 r=0 turn=000", lc, rc, turn);
        end
    endtask

    task automatic test_async_reset;
        int n, pulses;
        enable = 1'b1;
        sensor = 3'b000;
        wait_turn(3'b100, 20, n);
        vectors++;
        if ({turn, l_dir, r_dir} !== 5'b100_10) begin
            miscompares++;
            $display("[TB] FAIL search_pivot_right: got %b expected %b", {turn, l_dir, r_dir}, 5'b100_10);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir, node_pulse, lost} !== 10'b000_1_00_11_00) begin
            miscompares++;
            $display("[TB] FAIL async_reset_search: got %b expected %b",
                     {turn, motor_stopped, l_pwm, r_pwm, l_dir, r_dir, node_pulse, lost}, 10'b000_1_00_11_00);
        end
        tick();
        reset  = 1'b1;
        sensor = 3'b010;
        tick();
        vectors++;
        if ({turn, l_dir, r_dir} !== 5'b100_01) begin
            miscompares++;
            $display("[TB] FAIL reset_last_side: got %b expected %b", {turn, l_dir, r_dir}, 5'b100_01);
        end
        wait_turn(3'b001, 20, n);
        sensor = 3'b111;
        n = 0;
        while (node_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (node_pulse !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL node_before_reset: got %b expected %b", node_pulse, 1'b1);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({turn, node_pulse, motor_stopped} !== 5'b000_0_1) begin
            miscompares++;
            $display("[TB] FAIL async_reset_node: got %b expected %b", {turn, node_pulse, motor_stopped}, 5'b000_0_1);
        end
        tick();
        reset  = 1'b1;
        sensor = 3'b010;
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(node_pulse);
        end
        vectors++;
        if (pulses !== 0 || turn !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL post_reset_residue: got %0d pulses turn=%b expected 0 turn=001", pulses, turn);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_left_search();
        test_lost();
        test_node();
        test_glitch();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
